// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, ALU op codes and condition codes shared by the sequencer
package ctrl_pkg;
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_FETCH  = 6'b000010,
    S_DECODE = 6'b000100,
    S_EXEC   = 6'b001000,
    S_WB     = 6'b010000,
    S_TRAP   = 6'b100000
  } state_e;
  localparam logic [3:0] CLS_ILL = 4'd0;
  localparam logic [3:0] CLS_SGL = 4'd1;
  localparam logic [3:0] CLS_DBL = 4'd4;
  localparam logic [4:0] ALU_CMP  = 5'd5;
  localparam logic [4:0] ALU_BIT  = 5'd7;
  localparam logic [4:0] ALU_RRC  = 5'd16;
  localparam logic [4:0] ALU_RRCB = 5'd17;
  localparam logic [4:0] ALU_SWPB = 5'd18;
  localparam logic [4:0] ALU_RRA  = 5'd19;
  localparam logic [4:0] ALU_RRAB = 5'd20;
  localparam logic [4:0] ALU_SXT  = 5'd21;
  localparam logic [4:0] ALU_NOP  = 5'd31;
  localparam logic [2:0] C_NZ = 3'd0, C_Z = 3'd1, C_NC = 3'd2, C_C = 3'd3;
  localparam logic [2:0] C_N = 3'd4, C_GE = 3'd5, C_L = 3'd6, C_AL = 3'd7;
  // {valid, op} for a single-op sub-code; invalid sub-codes return all zeros
  function automatic logic [5:0] sgl_op(input logic [5:0] sub);
    case (sub)
      6'd0:    sgl_op = {1'b1, ALU_RRC};
      6'd1:    sgl_op = {1'b1, ALU_RRCB};
      6'd2:    sgl_op = {1'b1, ALU_SWPB};
      6'd4:    sgl_op = {1'b1, ALU_RRA};
      6'd5:    sgl_op = {1'b1, ALU_RRAB};
      6'd6:    sgl_op = {1'b1, ALU_SXT};
      default: sgl_op = '0;
    endcase
  endfunction
  // jump condition against flags ordered {V,N,C,Z}
  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      C_NZ:    cond_met = !f[0];
      C_Z:     cond_met = f[0];
      C_NC:    cond_met = !f[1];
      C_C:     cond_met = f[1];
      C_N:     cond_met = f[2];
      C_GE:    cond_met = f[2] == f[3];
      C_L:     cond_met = f[2] != f[3];
      default: cond_met = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decode into register, ALU and branch controls
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4,
  parameter int OFF_W  = 10
) (
  input  logic [15:0]       ir,
  output logic [4:0]        alu_op,
  output logic [REG_AW-1:0] src,
  output logic [REG_AW-1:0] dst,
  output logic [REG_AW-1:0] wr,
  output logic              is_jump,
  output logic [2:0]        cond,
  output logic              writes,
  output logic              illegal,
  output logic [ADDR_W-1:0] boff
);
  logic [3:0] cls;
  logic [5:0] sop;
  logic       dbl;
  assign cls = ir[15:12];
  assign sop = sgl_op(ir[11:6]);
  assign dbl = cls >= CLS_DBL;
  // class dispatch; compare-type double-ops and jumps never write back
  always_comb begin
    is_jump = ir[15:13] == 3'b001;
    cond    = ir[12:10];
    illegal = cls == CLS_ILL || (cls == CLS_SGL && !sop[5]);
    alu_op  = cls == CLS_SGL ? sop[4:0] : is_jump ? ALU_NOP : dbl ? {1'b0, cls - CLS_DBL} : '0;
    src     = dbl ? REG_AW'(ir[11:8]) : '0;
    dst     = (dbl || cls == CLS_SGL) ? REG_AW'(ir[3:0]) : '0;
    wr      = dst;
    writes  = !illegal && !is_jump && alu_op != ALU_CMP && alu_op != ALU_BIT;
    boff    = is_jump ? {{(ADDR_W-OFF_W-1){ir[OFF_W-1]}}, ir[OFF_W-1:0], 1'b0} : '0;
  end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multicycle fetch/decode/exec/writeback sequencer with illegal-op trap
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_AW  = 4,
  parameter int OFF_W   = 10,
  parameter int MEM_REG = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [3:0]        flags,
  output logic              mem_req,
  output logic              pc_inc,
  output logic              branch_en,
  output logic [ADDR_W-1:0] branch_off,
  output logic [4:0]        alu_op,
  output logic [REG_AW-1:0] src_reg,
  output logic [REG_AW-1:0] dst_reg,
  output logic [REG_AW-1:0] wr_reg,
  output logic              wr_en,
  output logic              wr_mem_en,
  output logic              trap,
  output logic [5:0]        state
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              is_jump, writes, illegal;
  logic [2:0]        cond;
  ctrl_decode #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .OFF_W(OFF_W)) u_dec (
    .ir      (ir_q),
    .alu_op  (alu_op),
    .src     (src_reg),
    .dst     (dst_reg),
    .wr      (wr_reg),
    .is_jump (is_jump),
    .cond    (cond),
    .writes  (writes),
    .illegal (illegal),
    .boff    (branch_off)
  );
  assign mem_req   = state_q == S_FETCH;
  assign pc_inc    = mem_req && mem_ready;
  assign branch_en = state_q == S_EXEC && is_jump && cond_met(cond, flags);
  assign wr_en     = state_q == S_WB && writes;
  assign wr_mem_en = wr_en && wr_reg == REG_AW'(MEM_REG);
  assign trap      = state_q == S_TRAP;
  assign state     = state_q;
  // next state; run is only consulted in IDLE and at WB exit, TRAP holds until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    ir_d = pc_inc ? mem_rdata : ir_q;
  end
  // state and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench for the instruction sequencer
module tb_ctrl_sequencer;
  localparam logic [5:0] ST_IDLE = 6'b000001, ST_FETCH = 6'b000010, ST_DECODE = 6'b000100;
  localparam logic [5:0] ST_EXEC = 6'b001000, ST_WB = 6'b010000, ST_TRAP = 6'b100000;
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [3:0]  flags = '0;
  logic        mem_req, pc_inc, branch_en, wr_en, wr_mem_en, trap;
  logic [15:0] branch_off;
  logic [4:0]  alu_op;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic [5:0]  state;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [4:0]  alu;
    logic [3:0]  src, dst, wr;
    logic        wen, wmem, ben, trap, jmp;
    logic [15:0] boff;
  } exp_t;
  exp_t sb[$];
  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .flags(flags), .mem_req(mem_req), .pc_inc(pc_inc), .branch_en(branch_en),
    .branch_off(branch_off), .alu_op(alu_op), .src_reg(src_reg), .dst_reg(dst_reg),
    .wr_reg(wr_reg), .wr_en(wr_en), .wr_mem_en(wr_mem_en), .trap(trap), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
  function automatic exp_t model(input logic [15:0] ins, input logic [3:0] fl);
    exp_t e;
    logic [3:0] c;
    logic v, n, cf, z;
    logic signed [15:0] s;
    c = ins[15:12];
    {v, n, cf, z} = fl;
    e.alu = 0; e.src = 0; e.dst = 0; e.wr = 0; e.wen = 0; e.wmem = 0;
    e.ben = 0; e.trap = 0; e.jmp = 0; e.boff = 0;
    if (c == 0) e.trap = 1;
    else if (c == 1) begin
      case (ins[11:6])
        6'd0: e.alu = 16;
        6'd1: e.alu = 17;
        6'd2: e.alu = 18;
        6'd4: e.alu = 19;
        6'd5: e.alu = 20;
        6'd6: e.alu = 21;
        default: e.trap = 1;
      endcase
      e.dst = ins[3:0]; e.wr = ins[3:0]; e.wen = !e.trap;
    end else if (c == 2 || c == 3) begin
      e.jmp = 1; e.alu = 31;
      case ({ins[12], ins[11:10]})
        3'd0: e.ben = !z;
        3'd1: e.ben = z;
        3'd2: e.ben = !cf;
        3'd3: e.ben = cf;
        3'd4: e.ben = n;
        3'd5: e.ben = n == v;
        3'd6: e.ben = n != v;
        default: e.ben = 1;
      endcase
      s = {{6{ins[9]}}, ins[9:0]};
      e.boff = s + s;
    end else begin
      e.alu = 5'(c) - 5'd4;
      e.src = ins[11:8]; e.dst = ins[3:0]; e.wr = ins[3:0];
      e.wen = c != 4'd9 && c != 4'd11;
    end
    e.wmem = e.wen && e.wr == 4'd9;
    return e;
  endfunction
  task automatic exec_instr(input logic [15:0] ins, input logic [3:0] fl, input int waits,
                            input bit drop_mid, input bit run_after, input logic [5:0] exp_start,
                            output int pc_cyc, output int wb_cyc);
    exp_t e, o;
    bit done;
    int cyc, fcnt, mreq, pinc, ovl, f0;
    logic [31:0] g[12], w[12];
    string nm[12] = '{"alu_op", "src_reg", "dst_reg", "wr_reg", "wr_en", "wr_mem_en", "branch_en",
                      "branch_off", "latency", "mem_req_cycles", "pc_inc_count", "pulse_overlap"};
    sb.push_back(model(ins, fl));
    mem_rdata = ins; flags = fl;
    o.alu = 0; o.src = 0; o.dst = 0; o.wr = 0; o.wen = 0; o.wmem = 0;
    o.ben = 0; o.trap = 0; o.jmp = 0; o.boff = 0;
    done = 0; cyc = 0; fcnt = 0; mreq = 0; pinc = 0; ovl = 0; f0 = -1; pc_cyc = -1; wb_cyc = -1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) run = 1'b1;
      mem_ready = state == ST_FETCH && fcnt >= waits;
      #1;
      if (cyc == 0) begin
        n_tests++;
        if (state !== exp_start) begin
          n_fail++;
          $display("FAIL start_state ins=%h: got %b expected %b", ins, state, exp_start);
        end
      end
      if (state == ST_FETCH) begin
        if (f0 < 0) f0 = cyc;
        fcnt++;
      end
      mreq += int'(mem_req);
      if (pc_inc) begin pinc++; pc_cyc = cyc; end
      o.ben |= branch_en; o.wen |= wr_en; o.wmem |= wr_mem_en;
      if (int'(pc_inc) + int'(branch_en) + int'(wr_en) > 1) ovl++;
      if (state == ST_DECODE) begin
        o.alu = alu_op; o.src = src_reg; o.dst = dst_reg; o.wr = wr_reg;
        if (drop_mid) run = 1'b0;
      end
      if (state == ST_EXEC) o.boff = branch_off;
      if (state == ST_WB) begin wb_cyc = cyc; done = 1; run = run_after; end
      if (state == ST_TRAP) begin o.trap = trap; done = 1; end
      cyc++;
    end
    mem_ready = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL completion ins=%h: no WB/TRAP within 40 cycles, state %b", ins, state);
    end
    if (e.trap) begin
      n_tests++;
      if (o.trap !== 1'b1) begin
        n_fail++;
        $display("FAIL trap ins=%h: got %b expected 1", ins, o.trap);
      end
    end
    g = '{32'(o.alu), 32'(o.src), 32'(o.dst), 32'(o.wr), 32'(o.wen), 32'(o.wmem), 32'(o.ben),
          32'(o.boff), 32'(wb_cyc - f0), 32'(mreq), 32'(pinc), 32'(ovl)};
    w = '{32'(e.alu), 32'(e.src), 32'(e.dst), 32'(e.wr), 32'(e.wen), 32'(e.wmem), 32'(e.ben),
          32'(e.boff), 32'(waits + 3), 32'(waits + 1), 32'd1, 32'd0};
    for (int i = 0; i < 12; i++)
      if ((!e.trap && (i != 7 || e.jmp)) || i == 9 || i == 10) begin
        n_tests++;
        if (g[i] !== w[i]) begin
          n_fail++;
          $display("FAIL %s ins=%h flags=%b: got %0h expected %0h", nm[i], ins, fl, g[i], w[i]);
        end
      end
  endtask
  task automatic test_reset;
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h4209; flags = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, ST_IDLE); end
    n_tests++;
    if ({mem_req, pc_inc, branch_en, wr_en, wr_mem_en, trap} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 000000", {mem_req, pc_inc, branch_en, wr_en, wr_mem_en, trap});
    end
    n_tests++;
    if ({alu_op, src_reg, dst_reg, wr_reg, branch_off} !== 33'b0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected 0", {alu_op, src_reg, dst_reg, wr_reg, branch_off});
    end
    run = 1'b0; mem_ready = 1'b0; rst = 1'b0;
  endtask
  task automatic test_basic;
    int pc, wb;
    exec_instr(16'h5123, 4'h0, 0, 0, 1, ST_IDLE, pc, wb);
    n_tests++;
    if (pc !== 1) begin n_fail++; $display("FAIL pc_inc_cycle: got %0d expected 1", pc); end
    n_tests++;
    if (wb !== 4) begin n_fail++; $display("FAIL wb_cycle: got %0d expected 4", wb); end
    exec_instr(16'h9123, 4'h0, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h4209, 4'h0, 0, 0, 1, ST_FETCH, pc, wb);
  endtask
  task automatic test_jumps;
    int pc, wb;
    exec_instr(16'h2404, 4'b0001, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h2404, 4'b0000, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h3FFF, 4'b0000, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h3400, 4'b1100, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h3400, 4'b1000, 0, 0, 1, ST_FETCH, pc, wb);
    exec_instr(16'h3800, 4'b1000, 0, 0, 0, ST_FETCH, pc, wb);
  endtask
  task automatic test_wait_states;
    int pc, wb;
    exec_instr(16'h5123, 4'h0, 3, 0, 1, ST_IDLE, pc, wb);
  endtask
  task automatic test_run_drop;
    int pc, wb;
    exec_instr(16'h4123, 4'h0, 0, 1, 0, ST_FETCH, pc, wb);
    exec_instr(16'h1046, 4'h0, 1, 0, 1, ST_IDLE, pc, wb);
  endtask
  task automatic test_back_to_back;
    int pc, wb;
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) begin
      ins = {4'(4 + $urandom_range(11)), 12'($urandom)};
      exec_instr(ins, 4'($urandom), int'($urandom_range(2)), 0, i < 7, ST_FETCH, pc, wb);
    end
  endtask
  task automatic test_reset_mid;
    int c;
    c = 0;
    mem_rdata = 16'h2404; flags = 4'b0001; mem_ready = 1'b1; run = 1'b1;
    while (state !== ST_EXEC && c < 20) begin @(negedge clk); #1; c++; end
    n_tests++;
    if (state !== ST_EXEC) begin n_fail++; $display("FAIL reach_exec: got %b expected %b", state, ST_EXEC); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({state, branch_en, wr_en, wr_mem_en} !== {ST_IDLE, 3'b0}) begin
      n_fail++;
      $display("FAIL abort_exec: got %b expected %b", {state, branch_en, wr_en, wr_mem_en}, {ST_IDLE, 3'b0});
    end
    mem_rdata = 16'h5123; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if ({state, alu_op, dst_reg, branch_en, wr_en} !== {ST_IDLE, 5'd0, 4'd0, 2'b0}) begin
      n_fail++;
      $display("FAIL ready_during_rst: got %h expected %h", {state, alu_op, dst_reg, branch_en, wr_en}, {ST_IDLE, 5'd0, 4'd0, 2'b0});
    end
    mem_ready = 1'b0;
  endtask
  task automatic test_trap;
    int pc, wb;
    logic [15:0] bad[2] = '{16'h0000, 16'h1200};
    for (int k = 0; k < 2; k++) begin
      exec_instr(bad[k], 4'h0, 0, 0, 1, ST_IDLE, pc, wb);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        run = i[0]; mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({trap, state, mem_req, pc_inc, wr_en} !== {1'b1, ST_TRAP, 3'b0}) begin
          n_fail++;
          $display("FAIL trap_sticky ins=%h: got %b expected %b", bad[k], {trap, state, mem_req, pc_inc, wr_en}, {1'b1, ST_TRAP, 3'b0});
        end
      end
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({trap, state} !== {1'b0, ST_IDLE}) begin
        n_fail++;
        $display("FAIL trap_clear ins=%h: got %b expected %b", bad[k], {trap, state}, {1'b0, ST_IDLE});
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_jumps();
    test_wait_states();
    test_run_drop();
    test_back_to_back();
    test_reset_mid();
    test_trap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
